mem_dumper: RTL

- Readback counterpart of the UART programmer: reads a byte range out of program/data memory and pushes it, byte by byte, into the UART TX FIFO.
- Appends an 8-bit additive checksum so the host can verify a programmed image.
- Sits between the memory byte read port and the UART TX FIFO write side; enabled by the same board-level mode signal family as programming.

---
 rtl/mem_dumper.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_dumper.sv
// mem_dumper: reads a byte range out of memory and streams it into the UART
// TX FIFO, followed by an 8-bit additive checksum of the streamed bytes.
//
// Handshake rules, in one place:
//   - Memory side: memRdEn is a one-cycle strobe with memAddr. memRdData is
//     valid exactly one cycle later and is captured then, with no stall.
//   - TX side: txFfFull acts as an active-low ready. A byte transfers on
//     every cycle where txWrEn=1. txWrEn is only raised when txFfFull=0, so
//     a write never depends on the FIFO accepting it later. txData is only
//     meaningful while txWrEn=1.
//   - Control: dumpStart is a single-cycle request that is only seen in
//     IDLE with dumpEn=1. dumpEn=0 drops the block to IDLE on the next edge
//     and masks every strobe in the same cycle.
module mem_dumper #(
  parameter int MEM_SIZE = 32767
) (
  input  logic        clk,
  input  logic        rstB,
  input  logic        dumpEn,
  input  logic        dumpStart,
  input  logic [31:0] dumpBase,
  input  logic [31:0] dumpLen,
  output logic        memRdEn,
  output logic [31:0] memAddr,
  input  logic [7:0]  memRdData,
  input  logic        txFfFull,
  output logic        txWrEn,
  output logic [7:0]  txData,
  output logic        dumpBusy,
  output logic        dumpDone,
  output logic        dumpErr,
  output logic [2:0]  dbgState
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LATCH = 3'd2,
    S_PUSH  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_count;
  logic [7:0]  r_csum;
  logic [7:0]  r_byte;
  logic [7:0]  r_tx_data;
  logic        r_err;

  logic [32:0] w_end_sum;
  logic        w_range_bad;
  logic [7:0]  w_next_csum;
  logic [31:0] w_next_count;
  logic        w_last_byte;
  logic        w_push_fire;
  logic        w_csum_fire;

  // The end address is formed in 33 bits so that a 32-bit wrap cannot hide
  // an out-of-range request; any carry-out is automatically above MEM_SIZE.
  assign w_end_sum    = {1'b0, dumpBase} + {1'b0, dumpLen};
  assign w_range_bad  = (w_end_sum > 33'(MEM_SIZE));

  assign w_next_csum  = r_csum + r_byte;
  assign w_next_count = r_count - 32'd1;
  assign w_last_byte  = (w_next_count == 32'd0);

  // A TX write happens only in a byte-emitting state, with room in the
  // FIFO, while the block is still enabled.
  assign w_push_fire  = (r_state == S_PUSH) && dumpEn && !txFfFull;
  assign w_csum_fire  = (r_state == S_CSUM) && dumpEn && !txFfFull;

  // Control FSM: state, address/count/checksum bookkeeping and the held
  // TX data byte all advance together here.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'd0;
      r_count   <= 32'd0;
      r_csum    <= 8'd0;
      r_byte    <= 8'd0;
      r_tx_data <= 8'd0;
      r_err     <= 1'b0;
    end else if (!dumpEn) begin
      // Abort: return to IDLE and forget the transfer. The error flag is
      // sticky and survives, and the TX data byte simply holds.
      r_state <= S_IDLE;
      r_addr  <= 32'd0;
      r_count <= 32'd0;
      r_csum  <= 8'd0;
      r_byte  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dumpStart) begin
            if (w_range_bad) begin
              r_err <= 1'b1;
            end else begin
              r_err   <= 1'b0;
              r_addr  <= dumpBase;
              r_count <= dumpLen;
              r_csum  <= 8'd0;
              if (dumpLen != 32'd0) begin
                r_state <= S_RD;
              end else begin
                // Empty range: go straight to the checksum, which is zero.
                r_tx_data <= 8'd0;
                r_state   <= S_CSUM;
              end
            end
          end
        end

        S_RD: begin
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          r_byte    <= memRdData;
          r_tx_data <= memRdData;
          r_state   <= S_PUSH;
        end

        S_PUSH: begin
          if (!txFfFull) begin
            r_csum  <= w_next_csum;
            r_count <= w_next_count;
            if (w_last_byte) begin
              // The address stays on the last byte read so that it never
              // steps to one past the end of memory.
              r_tx_data <= w_next_csum;
              r_state   <= S_CSUM;
            end else begin
              r_addr  <= r_addr + 32'd1;
              r_state <= S_RD;
            end
          end
        end

        S_CSUM: begin
          if (!txFfFull) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The strobes are decoded from the registered state and gated by dumpEn,
  // so an abort masks them in the same cycle. Because the state is
  // asynchronously reset, the strobes also clear as soon as reset asserts.
  assign memRdEn  = (r_state == S_RD) && dumpEn;
  assign memAddr  = (r_state == S_IDLE) ? 32'd0 : r_addr;
  assign txWrEn   = w_push_fire || w_csum_fire;
  assign txData   = r_tx_data;
  assign dumpBusy = (r_state != S_IDLE);
  assign dumpDone = (r_state == S_DONE) && dumpEn;
  assign dumpErr  = r_err;
  assign dbgState = r_state;

endmodule
